// File: rtl/vector_decimator_pkg.sv
// Shared types and constants for the vector decimator: lane count, mode and
// accumulator state encodings, plus the raw-mode decoder.
package vector_decimator_pkg;

    localparam int unsigned LANES      = 4;
    localparam int unsigned LANES_W    = 3;
    localparam int unsigned LANE_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam logic [LANES_W-1:0] LANES_FULL = LANES_W'(4);
    localparam logic [LANES_W-1:0] LANES_HALF = LANES_W'(2);

    typedef enum logic [1:0] {
        MODE_PASS       = 2'b00,
        MODE_DUP_INV    = 2'b01,
        MODE_INTERP_INV = 2'b10
    } mode_t;

    typedef enum logic {
        ACC_EMPTY = 1'b0,
        ACC_HALF  = 1'b1
    } acc_state_t;

    // Encoding 2'b11 is reserved and behaves as PASS.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        mode_t m;
        case (raw)
            2'b01:   m = MODE_DUP_INV;
            2'b10:   m = MODE_INTERP_INV;
            default: m = MODE_PASS;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vector_decimator_if.sv
// Beat-in / vector-out stream bundle for the vector decimator.
interface vector_decimator_if #(
    parameter int unsigned LANE_W = 32,
    parameter int unsigned CNT_W  = 16
);
    import vector_decimator_pkg::*;

    localparam int unsigned VEC_W = LANES * LANE_W;

    logic [1:0]         mode;
    logic               in_valid;
    logic               in_ready;
    logic [VEC_W-1:0]   in_data;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [VEC_W-1:0]   out_data;
    logic [LANES_W-1:0] out_lanes;
    logic [CNT_W-1:0]   vec_count;

    modport master (
        output mode, in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_lanes, vec_count
    );

    modport slave (
        input  mode, in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_lanes, vec_count
    );

endinterface

// File: rtl/vector_decimator_lane_select.sv
// Picks the two surviving lanes of a decimating beat: lane 0 always, then
// lane 2 for duplicate-inverse or lane 3 for interpolate-inverse.
module vector_decimator_lane_select
    import vector_decimator_pkg::*;
#(
    parameter int unsigned LANE_W = 32
) (
    input  mode_t             mode,
    input  logic [LANE_W-1:0] lane0,
    input  logic [LANE_W-1:0] lane2,
    input  logic [LANE_W-1:0] lane3,
    output logic [LANE_W-1:0] sel0,
    output logic [LANE_W-1:0] sel1
);

    always_comb begin
        sel0 = lane0;
        sel1 = lane2;
        if (mode == MODE_INTERP_INV) begin
            sel1 = lane3;
        end
    end

endmodule

// File: rtl/vector_decimator.sv
// Strips upsampled lanes from 4-lane vector beats and packs the survivors two
// beats per output vector; PASS beats go straight through.
module vector_decimator
    import vector_decimator_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    vector_decimator_if.slave  bus
);

    localparam int unsigned VEC_W = LANES * LANE_W;
    localparam int unsigned ACC_W = 2 * LANE_W;

    acc_state_t         state;
    logic [ACC_W-1:0]   acc;
    logic               flush_pend;
    logic               out_valid;
    logic [VEC_W-1:0]   out_data;
    logic [LANES_W-1:0] out_lanes;
    logic [CNT_W-1:0]   vec_count;

    mode_t              beat_mode;
    logic               beat_pass;
    logic [LANE_W-1:0]  sel0;
    logic [LANE_W-1:0]  sel1;
    logic               slot_free;
    logic               ready_c;
    logic               accept;
    logic               partial_c;

    assign beat_mode = decode_mode(bus.mode);
    assign beat_pass = (beat_mode == MODE_PASS);
    assign slot_free = !out_valid || bus.out_ready;

    vector_decimator_lane_select #(.LANE_W(LANE_W)) u_lane_select (
        .mode  (beat_mode),
        .lane0 (bus.in_data[0*LANE_W +: LANE_W]),
        .lane2 (bus.in_data[2*LANE_W +: LANE_W]),
        .lane3 (bus.in_data[3*LANE_W +: LANE_W]),
        .sel0  (sel0),
        .sel1  (sel1)
    );

    // A PASS beat cannot merge with a half vector, so it waits for the flush.
    always_comb begin
        ready_c = 1'b0;
        if (!rst) begin
            if (state == ACC_HALF && bus.in_valid && beat_pass) begin
                ready_c = 1'b0;
            end else begin
                ready_c = slot_free;
            end
        end
    end

    assign accept    = bus.in_valid && ready_c;
    assign partial_c = (state == ACC_HALF) && !accept && slot_free &&
                       ((bus.in_valid && beat_pass) || bus.flush || flush_pend);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACC_EMPTY;
            acc        <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_lanes  <= '0;
            vec_count  <= '0;
        end else begin
            if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
                vec_count <= vec_count + CNT_W'(1);
            end

            if (state == ACC_EMPTY) begin
                if (accept) begin
                    if (beat_pass) begin
                        out_data  <= bus.in_data;
                        out_lanes <= LANES_FULL;
                        out_valid <= 1'b1;
                    end else begin
                        acc   <= {sel1, sel0};
                        state <= ACC_HALF;
                    end
                end
            end else begin
                // Completing beat outranks any flush seen in the same cycle.
                if (accept) begin
                    out_data   <= {sel1, sel0, acc};
                    out_lanes  <= LANES_FULL;
                    out_valid  <= 1'b1;
                    state      <= ACC_EMPTY;
                    flush_pend <= 1'b0;
                end else if (partial_c) begin
                    out_data   <= {ACC_W'(0), acc};
                    out_lanes  <= LANES_HALF;
                    out_valid  <= 1'b1;
                    state      <= ACC_EMPTY;
                    flush_pend <= 1'b0;
                end else if (bus.flush) begin
                    flush_pend <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_lanes = out_lanes;
    assign bus.vec_count = vec_count;

endmodule

// File: tb/tb_vector_decimator.sv
// Self-checking bench for vector_decimator: directed scenarios followed by
// random traffic, all compared against a sample-queue reference model.
module tb_vector_decimator;
    import vector_decimator_pkg::*;

    localparam int unsigned LANE_W = 32;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned VEC_W  = 4 * LANE_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_decimator_if #(.LANE_W(LANE_W), .CNT_W(CNT_W)) bus ();

    vector_decimator #(.LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: surviving samples waiting to be packed, plus output reg.
    logic [LANE_W-1:0] m_acc[$];
    logic              m_fp;
    logic              m_ov;
    logic [VEC_W-1:0]  m_data;
    logic [2:0]        m_lanes;
    int unsigned       m_count;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] vec4(input int unsigned a3, input int unsigned a2,
                                              input int unsigned a1, input int unsigned a0);
        return {LANE_W'(a3), LANE_W'(a2), LANE_W'(a1), LANE_W'(a0)};
    endfunction

    function automatic logic [VEC_W-1:0] pack_acc();
        logic [VEC_W-1:0] v = '0;
        for (int k = 0; k < m_acc.size(); k++) v[k*LANE_W +: LANE_W] = m_acc[k];
        return v;
    endfunction

    task automatic step(input logic r, input logic v, input logic [1:0] md,
                        input logic [VEC_W-1:0] d, input logic f, input logic ordy);
        logic slot_free, is_pass, exp_rdy, acc, fire, load;
        logic [VEC_W-1:0] nd;
        logic [2:0] nl;
        @(negedge clk);
        rst = r; bus.in_valid = v; bus.mode = md; bus.in_data = d;
        bus.flush = f; bus.out_ready = ordy;
        #1;
        slot_free = !m_ov || ordy;
        is_pass   = (md == 2'b00) || (md == 2'b11);
        if (r) exp_rdy = 1'b0;
        else if (m_acc.size() != 0 && v && is_pass) exp_rdy = 1'b0;
        else exp_rdy = slot_free;
        chk("in_ready", VEC_W'(bus.in_ready), VEC_W'(exp_rdy));

        if (r) begin
            m_acc.delete(); m_fp = 1'b0; m_ov = 1'b0;
            m_data = '0; m_lanes = '0; m_count = 0;
        end else begin
            acc  = v && exp_rdy;
            fire = m_ov && ordy;
            load = 1'b0; nd = '0; nl = '0;
            if (fire) m_count = (m_count + 1) % (1 << CNT_W);
            if (acc && is_pass) begin
                nd = d; nl = 3'd4; load = 1'b1;
            end else if (acc) begin
                m_acc.push_back(d[0 +: LANE_W]);
                m_acc.push_back(md == 2'b10 ? d[3*LANE_W +: LANE_W] : d[2*LANE_W +: LANE_W]);
                if (m_acc.size() == 4) begin
                    nd = pack_acc(); nl = 3'd4; load = 1'b1;
                    m_acc.delete(); m_fp = 1'b0;
                end
            end else if (m_acc.size() != 0 && slot_free && ((v && is_pass) || f || m_fp)) begin
                nd = pack_acc(); nl = 3'd2; load = 1'b1;
                m_acc.delete(); m_fp = 1'b0;
            end else if (m_acc.size() != 0 && f) begin
                m_fp = 1'b1;
            end
            if (load) begin
                m_ov = 1'b1; m_data = nd; m_lanes = nl;
            end else if (fire) begin
                m_ov = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        chk("out_valid", VEC_W'(bus.out_valid), VEC_W'(m_ov));
        chk("out_data",  bus.out_data, m_data);
        chk("out_lanes", VEC_W'(bus.out_lanes), VEC_W'(m_lanes));
        chk("vec_count", VEC_W'(bus.vec_count), VEC_W'(m_count));
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 2'b00, '0, 1'b0, ordy);
    endtask

    initial begin
        m_fp = 1'b0; m_ov = 1'b0; m_data = '0; m_lanes = '0; m_count = 0;
        rst = 1'b1; bus.in_valid = 1'b0; bus.mode = 2'b00; bus.in_data = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;

        step(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'b00, vec4(1, 1, 1, 1), 1'b0, 1'b1);
        chk("reset_data", bus.out_data, '0);

        // PASS beat goes straight through
        step(1'b0, 1'b1, 2'b00, vec4(4, 3, 2, 1), 1'b0, 1'b1);
        chk("t1_data", bus.out_data, vec4(4, 3, 2, 1));
        chk("t1_lanes", VEC_W'(bus.out_lanes), VEC_W'(4));
        idle(1'b1);
        chk("t1_count", VEC_W'(bus.vec_count), VEC_W'(1));

        // Duplicate-inverse pairs packed oldest first
        step(1'b0, 1'b1, 2'b01, vec4(11, 11, 10, 10), 1'b0, 1'b1);
        chk("t2_not_yet", VEC_W'(bus.out_valid), VEC_W'(0));
        step(1'b0, 1'b1, 2'b01, vec4(13, 13, 12, 12), 1'b0, 1'b1);
        chk("t2_data", bus.out_data, vec4(13, 12, 11, 10));
        idle(1'b1);

        // Interpolate-inverse, then backpressure holds the vector
        step(1'b0, 1'b1, 2'b10, vec4(9, 7, 5, 3), 1'b0, 1'b1);
        step(1'b0, 1'b1, 2'b10, vec4(30, 20, 10, 0), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, vec4(8, 8, 8, 8), 1'b0, 1'b0);
        chk("t3_hold", bus.out_data, vec4(30, 0, 9, 3));
        idle(1'b1);

        // Flush of a half vector; flush while empty emits nothing
        step(1'b0, 1'b1, 2'b01, vec4(6, 6, 5, 5), 1'b0, 1'b1);
        step(1'b0, 1'b0, 2'b00, '0, 1'b1, 1'b1);
        chk("t4_data", bus.out_data, vec4(0, 0, 6, 5));
        chk("t4_lanes", VEC_W'(bus.out_lanes), VEC_W'(2));
        idle(1'b1);
        step(1'b0, 1'b0, 2'b00, '0, 1'b1, 1'b1);
        chk("t4_empty_flush", VEC_W'(bus.out_valid), VEC_W'(0));

        // Half vector then PASS: auto-flush first, PASS beat next
        step(1'b0, 1'b1, 2'b10, vec4(44, 0, 0, 33), 1'b0, 1'b1);
        step(1'b0, 1'b1, 2'b11, vec4(7, 6, 5, 4), 1'b0, 1'b1);
        chk("t5_partial", bus.out_data, vec4(0, 0, 44, 33));
        step(1'b0, 1'b1, 2'b11, vec4(7, 6, 5, 4), 1'b0, 1'b1);
        chk("t5_pass", bus.out_data, vec4(7, 6, 5, 4));
        idle(1'b1);

        // Reset with a pending output and with a half vector
        step(1'b0, 1'b1, 2'b00, vec4(1, 2, 3, 4), 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0);
        chk("t6_rst_valid", VEC_W'(bus.out_valid), VEC_W'(0));
        step(1'b0, 1'b1, 2'b01, vec4(2, 2, 1, 1), 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 2'b00, '0, 1'b1, 1'b1);
        chk("t6_acc_gone", VEC_W'(bus.out_valid), VEC_W'(0));

        // Counter wraps after four vectors
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b00, vec4(i, i, i, i), 1'b0, 1'b1);
        idle(1'b1);
        chk("wrap", VEC_W'(bus.vec_count), VEC_W'(0));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 70),
                 2'($urandom_range(0, 3)),
                 {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 60));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
